// File: rtl/neuron_pkg.sv
// Shared definitions for the perceptron sequencer: datapath widths, the
// pipeline tag that travels alongside each chunk, and the queued result record.
package neuron_pkg;

    localparam int LANE_W    = 16;
    localparam int ACC_W     = 48;
    localparam int MAX_LANES = 16;

    // Travels through the latency pipe alongside one issued chunk.
    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    // One completed neuron evaluation as stored in the output FIFO.
    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic             fire;
        logic             ovf;
    } result_t;

    // Signed overflow of s = a + b: both operands agree in sign, result does not.
    function automatic logic add_overflow(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input logic [ACC_W-1:0] s
    );
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

endpackage

// File: rtl/perceptron_result_fifo.sv
// First-word-fall-through result FIFO. The head entry is visible whenever
// count is non-zero; a pop on a full FIFO frees the slot a same-cycle push uses.
module perceptron_result_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [IDX_W-1:0] wr_ptr_r;
    logic [IDX_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? {IDX_W{1'b0}} : p + IDX_W'(1);
    endfunction

    // Qualify requests: never pop when empty, never push into a full FIFO
    // unless the head leaves in the same cycle.
    always_comb begin
        pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
        push_ok_s = push && ((count_r < CNT_W'(DEPTH)) || pop_ok_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {IDX_W{1'b0}};
            rd_ptr_r <= {IDX_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/perceptron_sequencer.sv
// Streams chunked input/weight vectors into a fixed-latency weighted-sum
// datapath, accumulates the returning partial sums into a dot product,
// thresholds it and queues the result. Admission is credit-gated so a
// completed result always has a FIFO slot waiting for it.
module perceptron_sequencer
    import neuron_pkg::*;
#(
    parameter int M           = 8,
    parameter int SUM_LATENCY = 10,
    parameter int OUT_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANE_W*M-1:0]   in_x,
    input  logic [LANE_W*M-1:0]   in_w,
    input  logic                  in_last,
    output logic [LANE_W*M-1:0]   ds_x,
    output logic [LANE_W*M-1:0]   ds_w,
    input  logic [ACC_W-1:0]      ds_sum,
    input  logic [ACC_W-1:0]      threshold,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_sum,
    output logic                  out_fire,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    // Admission / credit
    logic             in_ready_r;
    logic [CNT_W-1:0] reserved_r;       // results queued plus vectors in flight
    logic [CNT_W-1:0] reserved_next_s;
    logic             accept_s;
    logic             pop_s;

    // Issue stage and latency pipe
    logic [LANE_W*M-1:0] ds_x_r;
    logic [LANE_W*M-1:0] ds_w_r;
    tag_t                issue_tag_r;
    tag_t                tag_pipe_r [SUM_LATENCY];
    tag_t                tag_out_s;
    logic                pipe_busy_s;

    // Accumulator
    logic [ACC_W-1:0] acc_r;
    logic             ovf_r;
    logic             first_r;
    logic [ACC_W-1:0] base_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             ovf_next_s;
    logic             push_s;
    result_t          push_res_s;

    // Output FIFO
    result_t          head_s;
    logic [CNT_W-1:0] fifo_count_s;

    assign accept_s  = in_valid & in_ready_r;
    assign out_valid = (fifo_count_s != {CNT_W{1'b0}});
    assign pop_s     = out_valid & out_ready;

    // Next reservation count: a last chunk claims a slot, a pop returns one.
    always_comb begin
        case ({accept_s & in_last, pop_s})
            2'b10:   reserved_next_s = reserved_r + CNT_W'(1);
            2'b01:   reserved_next_s = reserved_r - CNT_W'(1);
            default: reserved_next_s = reserved_r;
        endcase
    end

    // Credit state; in_ready is registered so it never depends on in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reserved_r <= {CNT_W{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            reserved_r <= reserved_next_s;
            in_ready_r <= (reserved_next_s < CNT_W'(OUT_DEPTH));
        end
    end

    // Issue register: accepted chunk one cycle later, zero bubble otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_x_r      <= {(LANE_W*M){1'b0}};
            ds_w_r      <= {(LANE_W*M){1'b0}};
            issue_tag_r <= '0;
        end else if (accept_s) begin
            ds_x_r      <= in_x;
            ds_w_r      <= in_w;
            issue_tag_r <= '{valid: 1'b1, last: in_last};
        end else begin
            ds_x_r      <= {(LANE_W*M){1'b0}};
            ds_w_r      <= {(LANE_W*M){1'b0}};
            issue_tag_r <= '0;
        end
    end

    // Tag pipe: the issued tag emerges in the cycle its ds_sum is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SUM_LATENCY; i++) begin
                tag_pipe_r[i] <= '0;
            end
        end else begin
            tag_pipe_r[0] <= issue_tag_r;
            for (int i = 1; i < SUM_LATENCY; i++) begin
                tag_pipe_r[i] <= tag_pipe_r[i-1];
            end
        end
    end

    assign tag_out_s = tag_pipe_r[SUM_LATENCY-1];

    // Any chunk still travelling through the latency pipe.
    always_comb begin
        pipe_busy_s = 1'b0;
        for (int i = 0; i < SUM_LATENCY; i++) begin
            pipe_busy_s = pipe_busy_s | tag_pipe_r[i].valid;
        end
    end

    // Next accumulator value, sticky overflow and the result to queue.
    always_comb begin
        base_s               = first_r ? {ACC_W{1'b0}} : acc_r;
        acc_next_s           = base_s + ds_sum;
        ovf_next_s           = ovf_r | add_overflow(base_s, ds_sum, acc_next_s);
        push_s               = tag_out_s.valid & tag_out_s.last;
        push_res_s.sum       = acc_next_s;
        push_res_s.fire      = ($signed(acc_next_s) >= $signed(threshold));
        push_res_s.ovf       = ovf_next_s;
    end

    // Accumulator: fold in each returning partial sum, restart after a last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= {ACC_W{1'b0}};
            ovf_r   <= 1'b0;
            first_r <= 1'b1;
        end else if (tag_out_s.valid && tag_out_s.last) begin
            acc_r   <= {ACC_W{1'b0}};
            ovf_r   <= 1'b0;
            first_r <= 1'b1;
        end else if (tag_out_s.valid) begin
            acc_r   <= acc_next_s;
            ovf_r   <= ovf_next_s;
            first_r <= 1'b0;
        end else begin
            acc_r   <= acc_r;
            ovf_r   <= ovf_r;
            first_r <= first_r;
        end
    end

    perceptron_result_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (OUT_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_res_s),
        .pop       (out_ready),
        .head_data (head_s),
        .count     (fifo_count_s)
    );

    assign in_ready = in_ready_r;
    assign ds_x     = ds_x_r;
    assign ds_w     = ds_w_r;
    assign out_sum  = head_s.sum;
    assign out_fire = head_s.fire;
    assign out_ovf  = head_s.ovf;
    assign busy     = issue_tag_r.valid | pipe_busy_s | ~first_r | out_valid;

endmodule

// File: tb/tb_perceptron_sequencer.sv
// Bench for perceptron_sequencer: a behavioural datapath (dot product plus an
// optional per-chunk bias, delayed by SUM_LATENCY), a result scoreboard, a
// table of single-chunk vectors and hand-written multi-cycle sequences.
module tb_perceptron_sequencer;

    localparam int M  = 8;
    localparam int L  = 10;
    localparam int D  = 4;
    localparam int XW = 16 * M;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_x;
    logic [XW-1:0] in_w;
    logic          in_last;
    logic [XW-1:0] ds_x;
    logic [XW-1:0] ds_w;
    logic [47:0]   ds_sum;
    logic [47:0]   threshold;
    logic          out_valid;
    logic          out_ready;
    logic [47:0]   out_sum;
    logic          out_fire;
    logic          out_ovf;
    logic          busy;

    perceptron_sequencer #(.M(M), .SUM_LATENCY(L), .OUT_DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .ds_x      (ds_x),
        .ds_w      (ds_w),
        .ds_sum    (ds_sum),
        .threshold (threshold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_fire  (out_fire),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural datapath ----------------
    logic [47:0] bias_in;
    logic [47:0] bias_s0 = 48'd0;
    logic [47:0] dp_pipe [L];

    function automatic logic [47:0] dot(input logic [XW-1:0] x, input logic [XW-1:0] w);
        logic signed [47:0] s;
        logic signed [47:0] a;
        logic signed [47:0] b;
        s = 48'sd0;
        for (int k = 0; k < M; k++) begin
            a = 48'($signed(x[16*k +: 16]));
            b = 48'($signed(w[16*k +: 16]));
            s = s + a * b;
        end
        return s;
    endfunction

    initial for (int i = 0; i < L; i++) dp_pipe[i] = 48'd0;

    // Datapath model: bias follows the accepted chunk into the ds stage.
    always @(posedge clk) begin
        bias_s0    <= (in_valid && in_ready) ? bias_in : 48'd0;
        dp_pipe[0] <= dot(ds_x, ds_w) + bias_s0;
        for (int i = 1; i < L; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign ds_sum = dp_pipe[L-1];

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [47:0] sum;
        logic        fire;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic signed [15:0] xv;
        logic signed [15:0] wv;
        int                 lanes;
        logic [47:0]        bias;
        logic [47:0]        thr;
        logic [47:0]        sum;
        logic               fire;
        logic               ovf;
    } vec_t;

    exp_t exp_q [$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_pop  = 0;
    int   acc_cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic void push_exp(input logic [47:0] s, input logic f, input logic o);
        exp_t e;
        e.sum = s; e.fire = f; e.ovf = o;
        exp_q.push_back(e);
    endfunction

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: got sum 0x%0h, required no result", out_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("out_sum", out_sum, e.sum);
                    check("out_fire", out_fire, e.fire);
                    check("out_ovf", out_ovf, e.ovf);
                end
            end
        end
    endtask

    task automatic drive(input logic signed [15:0] xv, input logic signed [15:0] wv,
                         input int lanes, input logic [47:0] bias, input logic last);
        in_x = '0;
        in_w = '0;
        for (int k = 0; k < lanes; k++) begin
            in_x[16*k +: 16] = xv;
            in_w[16*k +: 16] = wv;
        end
        bias_in  = bias;
        in_last  = last;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_x     = '0;
        in_w     = '0;
        bias_in  = 48'd0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic signed [15:0] xv, input logic signed [15:0] wv,
                        input int lanes, input logic [47:0] bias, input logic last);
        int t = 0;
        drive(xv, wv, lanes, bias, last);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0, required 1");
        end
        acc_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (exp_q.size() != 0 || busy) begin
            n_fail++;
            $display("FAIL %s drain: pending %0d busy %0b, required pending 0 busy 0",
                     name, exp_q.size(), busy);
        end
    endtask

    vec_t tbl [6];

    initial begin
        int t;
        int n_acc;
        int pops_before;

        tbl[0] = '{-16'sd5,     16'sd1,     1, 48'd0, 48'hFFFF_FFFF_FFFB, 48'hFFFF_FFFF_FFFB, 1'b1, 1'b0};
        tbl[1] = '{-16'sd5,     16'sd1,     1, 48'd0, 48'hFFFF_FFFF_FFFC, 48'hFFFF_FFFF_FFFB, 1'b0, 1'b0};
        tbl[2] = '{ 16'sd7,    -16'sd3,     1, 48'd0, 48'hFFFF_FFFF_FFEB, 48'hFFFF_FFFF_FFEB, 1'b1, 1'b0};
        tbl[3] = '{-16'sd32768,-16'sd32768, 8, 48'd0, 48'd0,              48'h0002_0000_0000, 1'b1, 1'b0};
        tbl[4] = '{ 16'sd0,     16'sd0,     8, 48'd0, 48'd1,              48'd0,              1'b0, 1'b0};
        tbl[5] = '{ 16'sd300,  -16'sd2,     4, 48'd0, 48'hFFFF_FFFF_F6A0, 48'hFFFF_FFFF_F6A0, 1'b1, 1'b0};

        idle();
        out_ready = 1'b1;
        threshold = 48'd0;
        fork
            monitor_loop();
        join_none

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_ds_x", ds_x, 128'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum", out_sum, 48'd0);
        check("rst_out_fire", out_fire, 1'b0);
        check("rst_out_ovf", out_ovf, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);

        // ---- single chunk, latency ----
        threshold = 48'd10;
        push_exp(48'd16, 1'b1, 1'b0);
        send(16'sd1, 16'sd2, 8, 48'd0, 1'b1);
        idle();
        check("issue_ds_x", ds_x, {8{16'h0001}});
        check("issue_ds_w", ds_w, {8{16'h0002}});
        @(negedge clk);
        check("bubble_ds_x", ds_x, 128'd0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("latency", 32'(cyc - acc_cyc), 32'(L + 2));
        wait_drain("single");

        // ---- three chunks with a mid-vector gap ----
        threshold = 48'd0;
        push_exp(48'hFFFF_FFFF_FF6A, 1'b0, 1'b0);
        send(16'sd100, 16'sd1, 1, 48'd0, 1'b0);
        idle();
        repeat (2) @(negedge clk);
        send(-16'sd300, 16'sd1, 1, 48'd0, 1'b0);
        send(16'sd50, 16'sd1, 1, 48'd0, 1'b1);
        idle();
        wait_drain("gap");

        // ---- table of single-chunk vectors ----
        for (int i = 0; i < 6; i++) begin
            threshold = tbl[i].thr;
            push_exp(tbl[i].sum, tbl[i].fire, tbl[i].ovf);
            send(tbl[i].xv, tbl[i].wv, tbl[i].lanes, tbl[i].bias, 1'b1);
            idle();
            wait_drain("table");
        end

        // ---- overflow, then a clean back-to-back vector ----
        threshold = 48'd0;
        push_exp(48'h8000_0000_0000, 1'b0, 1'b1);
        push_exp(48'd3, 1'b1, 1'b0);
        send(16'sd0, 16'sd0, 1, 48'h7FFF_FFFF_FFFF, 1'b0);
        send(16'sd1, 16'sd1, 1, 48'd0, 1'b1);
        send(16'sd3, 16'sd1, 1, 48'd0, 1'b1);
        idle();
        wait_drain("ovf");

        // ---- credit exhaustion with out_ready low ----
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            drive(16'(i + 1), 16'sd1, 1, 48'd0, 1'b1);
            if (in_ready) begin
                n_acc++;
                push_exp(48'(i + 1), 1'b1, 1'b0);
            end
            @(negedge clk);
        end
        idle();
        check("credit_accepted", 32'(n_acc), 32'(D));
        check("credit_in_ready", in_ready, 1'b0);
        repeat (L + 6) @(negedge clk);
        check("stall_out_valid", out_valid, 1'b1);
        repeat (3) @(negedge clk);
        check("stall_hold_sum", out_sum, 48'd1);
        out_ready = 1'b1;
        wait_drain("credit");
        check("credit_return", in_ready, 1'b1);

        // ---- reset with work in flight and queued ----
        out_ready = 1'b0;
        threshold = 48'd0;
        send(16'sd5, 16'sd1, 1, 48'd0, 1'b1);
        idle();
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        send(16'sd6, 16'sd1, 1, 48'd0, 1'b1);
        send(16'sd7, 16'sd1, 1, 48'd0, 1'b1);
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_sum", out_sum, 48'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ds_x", ds_x, 128'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        pops_before = n_pop;
        repeat (L + 8) @(negedge clk);
        check("post_rst_no_stale", 32'(n_pop - pops_before), 32'd0);
        push_exp(48'd9, 1'b1, 1'b0);
        send(16'sd9, 16'sd1, 1, 48'd0, 1'b1);
        idle();
        wait_drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
